// File: rtl/note_tone_pkg.sv
// note_tone_pkg: shared widths, FSM states and the note -> period table for note_tone_gen.
package note_tone_pkg;
    localparam int NOTE_W    = 6;
    localparam int PER_W_DEF = 20;

    typedef enum logic [1:0] {IDLE, PLAY, PEND} state_t;

    // Clocks per tone period at 50 MHz: note 1 = C2 ... note 34 = A4 ... note 63 = D7; entry 0 is the rest.
    localparam logic [PER_W_DEF-1:0] PERIOD_LUT [64] = '{
        20'd0,
        20'd764452, 20'd721546, 20'd681048, 20'd642824, 20'd606745, 20'd572691, 20'd540549, 20'd510210,
        20'd481574, 20'd454545, 20'd429034, 20'd404954, 20'd382226, 20'd360773, 20'd340524, 20'd321412,
        20'd303373, 20'd286346, 20'd270274, 20'd255105, 20'd240787, 20'd227273, 20'd214517, 20'd202477,
        20'd191113, 20'd180386, 20'd170262, 20'd160706, 20'd151686, 20'd143173, 20'd135137, 20'd127553,
        20'd120394, 20'd113636, 20'd107258, 20'd101238, 20'd95556,  20'd90193,  20'd85131,  20'd80353,
        20'd75843,  20'd71586,  20'd67569,  20'd63776,  20'd60197,  20'd56818,  20'd53629,  20'd50619,
        20'd47778,  20'd45097,  20'd42566,  20'd40177,  20'd37922,  20'd35793,  20'd33784,  20'd31888,
        20'd30098,  20'd28409,  20'd26815,  20'd25310,  20'd23889,  20'd22548,  20'd21283
    };

    function automatic int duty_shift(input logic [1:0] sel);
        return sel == 2'd1 ? 2 : sel == 2'd2 ? 3 : 1;
    endfunction
endpackage

// File: rtl/note_tone_gen_rom.sv
// note_period_rom: combinational note index -> tone period in clocks, scaled down by PERIOD_SHIFT.
module note_period_rom
    import note_tone_pkg::*;
#(
    parameter int PER_W        = PER_W_DEF,
    parameter int PERIOD_SHIFT = 0
) (
    input  logic [NOTE_W-1:0] note,
    output logic [PER_W-1:0]  period
);
    assign period = PER_W'(PERIOD_LUT[note] >> PERIOD_SHIFT);
endmodule

// File: rtl/note_tone_gen.sv
// note_tone_gen: note index -> glitch-free square-wave tone; note changes apply only at period wraps.
// Optional NOTE_TONE_DUTY_EN adds duty_sel (50/25/12.5% duty), sampled at each period start.
module note_tone_gen
    import note_tone_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int PER_W        = PER_W_DEF,
    parameter int PERIOD_SHIFT = 0
) (
    input  logic              clk50mhz,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NOTE_W-1:0] note_in,
`ifdef NOTE_TONE_DUTY_EN
    input  logic [1:0]        duty_sel,
`endif
    output logic              tone_out,
    output logic [NOTE_W-1:0] cur_note,
    output logic              per_strobe,
    output logic              chg_pend
);
    state_t            state, state_nx;
    logic [NOTE_W-1:0] note_q, cur_nx;
    logic [PER_W-1:0]  cnt, cnt_nx, per, per_nx, rom_per, h_nx;
    logic [1:0]        duty_nx;
    logic              wrap, start;

    if (CLK_HZ != 50_000_000) begin : g_clk_chk
        $error("note_tone_gen: period table is built for a 50 MHz clock");
    end

    note_period_rom #(.PER_W(PER_W), .PERIOD_SHIFT(PERIOD_SHIFT)) u_rom (.note(note_q), .period(rom_per));

    assign wrap     = cnt == per - 1'b1;
    assign chg_pend = state == PEND;

    // en low forces IDLE ahead of any wrap handling.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        per_nx   = per;
        cur_nx   = cur_note;
        start    = 1'b0;
        if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            cur_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nx = '0;
                    if (note_q != '0) begin
                        state_nx = PLAY;
                        per_nx   = rom_per;
                        cur_nx   = note_q;
                        start    = 1'b1;
                    end
                end
                PLAY: begin
                    if (wrap) begin
                        cnt_nx = '0;
                        start  = 1'b1;
                    end
                    if (note_q != cur_note) state_nx = PEND;
                end
                default: begin
                    if (wrap) begin
                        cnt_nx   = '0;
                        per_nx   = rom_per;
                        cur_nx   = note_q;
                        start    = note_q != '0;
                        state_nx = note_q == '0 ? IDLE : PLAY;
                    end else if (note_q == cur_note) begin
                        state_nx = PLAY;
                    end
                end
            endcase
        end
    end

`ifdef NOTE_TONE_DUTY_EN
    logic [1:0] duty_q;
    always_ff @(posedge clk50mhz or negedge rst_n)
        if (!rst_n) duty_q <= 2'd0;
        else duty_q <= duty_nx;
    assign duty_nx = start ? duty_sel : duty_q;
`else
    assign duty_nx = 2'd0;
`endif

    assign h_nx = per_nx >> duty_shift(duty_nx);

    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            note_q     <= '0;
            cur_note   <= '0;
            cnt        <= '0;
            per        <= '0;
            tone_out   <= 1'b0;
            per_strobe <= 1'b0;
        end else begin
            state      <= state_nx;
            note_q     <= note_in;
            cur_note   <= cur_nx;
            cnt        <= cnt_nx;
            per        <= per_nx;
            tone_out   <= (state_nx != IDLE) && (cnt_nx < h_nx);
            per_strobe <= start;
        end
    end
endmodule

// File: tb/tb_note_tone_gen.sv
// tb_note_tone_gen: scoreboard bench for note_tone_gen with the period table scaled by 2^-6.
module tb_note_tone_gen;
    localparam int SH = 6;
    // Reference periods/high times after the >>6 scaling, from the pitch formula.
    localparam int P34 = 113636 >> SH, H34 = P34 >> 1;
    localparam int P46 = 56818 >> SH,  H46 = P46 >> 1;
    localparam int P1  = 764452 >> SH, H1  = P1 >> 1;
    localparam int P63 = 21283 >> SH;

    typedef struct packed {
        logic [5:0] note;
        int         len;
        int         high;
    } per_t;

    logic       clk50mhz = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [5:0] note_in = 6'd0;
    logic       tone_out, per_strobe, chg_pend;
    logic [5:0] cur_note;
`ifdef NOTE_TONE_DUTY_EN
    logic [1:0] duty_sel = 2'd0;
`endif

    int   checks = 0, failures = 0;
    per_t exp_q[$], obs_q[$];
    per_t e, o;
    bit   ok;

    note_tone_gen #(.PERIOD_SHIFT(SH)) dut (
        .clk50mhz  (clk50mhz),
        .rst_n     (rst_n),
        .en        (en),
        .note_in   (note_in),
`ifdef NOTE_TONE_DUTY_EN
        .duty_sel  (duty_sel),
`endif
        .tone_out  (tone_out),
        .cur_note  (cur_note),
        .per_strobe(per_strobe),
        .chg_pend  (chg_pend)
    );

    always #5 clk50mhz = ~clk50mhz;

    // Monitor: one record per completed period (ended by the next strobe or by going silent).
    int         run_len, run_high;
    logic [5:0] run_note;
    bit         in_per = 1'b0;
    always @(negedge clk50mhz) begin
        if (!rst_n) begin
            in_per <= 1'b0;
        end else if (per_strobe) begin
            if (in_per) obs_q.push_back('{run_note, run_len, run_high});
            in_per   <= 1'b1;
            run_len  <= 1;
            run_high <= int'(tone_out);
            run_note <= cur_note;
        end else if (in_per) begin
            if (cur_note == 6'd0) begin
                obs_q.push_back('{run_note, run_len, run_high});
                in_per <= 1'b0;
            end else begin
                run_len  <= run_len + 1;
                run_high <= run_high + int'(tone_out);
            end
        end
    end

    task automatic wait_obs(input int n, input int budget, output bit got);
        for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge clk50mhz);
        got = obs_q.size() >= n;
    endtask

    task automatic wait_note(input logic [5:0] n, input int budget, output bit got);
        for (int i = 0; i < budget && cur_note !== n; i++) @(negedge clk50mhz);
        got = cur_note === n;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; note_in = 6'd0;
        repeat (3) @(negedge clk50mhz);
        checks++; if (tone_out !== 1'b0) begin failures++; $display("FAIL reset tone_out: got %b want 0", tone_out); end
        checks++; if (cur_note !== 6'd0) begin failures++; $display("FAIL reset cur_note: got %0d want 0", cur_note); end
        checks++; if (per_strobe !== 1'b0) begin failures++; $display("FAIL reset per_strobe: got %b want 0", per_strobe); end
        checks++; if (chg_pend !== 1'b0) begin failures++; $display("FAIL reset chg_pend: got %b want 0", chg_pend); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk50mhz);
    endtask

    task automatic test_async_reset;
        en = 1'b1; note_in = 6'd34;
        wait_note(6'd34, 20, ok);
        repeat (100) @(negedge clk50mhz);
        checks++; if (tone_out !== 1'b1) begin failures++; $display("FAIL async pre tone_out: got %b want 1", tone_out); end
        @(posedge clk50mhz);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tone_out, cur_note, per_strobe, chg_pend} !== 9'd0) begin
            failures++;
            $display("FAIL async reset outputs: got tone=%b note=%0d strobe=%b pend=%b want all 0",
                     tone_out, cur_note, per_strobe, chg_pend);
        end
        en = 1'b0; note_in = 6'd0;
        repeat (2) @(negedge clk50mhz);
        rst_n = 1'b1;
        @(negedge clk50mhz);
        #1 obs_q.delete();
    endtask

    task automatic test_tone;
        int lat;
        en = 1'b1; note_in = 6'd0;
        repeat (3) @(negedge clk50mhz);
        note_in = 6'd34;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(posedge clk50mhz);
            #1 if (tone_out === 1'b1) lat = i;
        end
        checks++; if (lat !== 2) begin failures++; $display("FAIL tone latency: got %0d want 2", lat); end
        repeat (2) exp_q.push_back('{6'd34, P34, H34});
        wait_obs(2, 3 * P34, ok);
        checks++; if (!ok) begin failures++; $display("FAIL tone timeout: got %0d periods want 2", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.size() > 0 ? obs_q.pop_front() : '0;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL tone period: got note=%0d len=%0d high=%0d want note=%0d len=%0d high=%0d",
                         o.note, o.len, o.high, e.note, e.len, e.high);
            end
        end
    endtask

    task automatic test_note_change;
        for (int i = 0; i < 2 * P34 && per_strobe !== 1'b1; i++) @(negedge clk50mhz);
        #1 obs_q.delete();
        repeat (500) @(negedge clk50mhz);
        note_in = 6'd46;
        repeat (3) @(negedge clk50mhz);
        checks++; if (chg_pend !== 1'b1) begin failures++; $display("FAIL change pend: got %b want 1", chg_pend); end
        checks++; if (cur_note !== 6'd34) begin failures++; $display("FAIL change held note: got %0d want 34", cur_note); end
        exp_q.push_back('{6'd34, P34, H34});
        exp_q.push_back('{6'd46, P46, H46});
        wait_obs(2, 2 * P34, ok);
        checks++; if (!ok) begin failures++; $display("FAIL change timeout: got %0d periods want 2", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.size() > 0 ? obs_q.pop_front() : '0;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL change period: got note=%0d len=%0d high=%0d want note=%0d len=%0d high=%0d",
                         o.note, o.len, o.high, e.note, e.len, e.high);
            end
        end
        checks++; if (chg_pend !== 1'b0) begin failures++; $display("FAIL change pend clear: got %b want 0", chg_pend); end
    endtask

    task automatic test_rest;
        bit strobed;
        note_in = 6'd1;
        wait_note(6'd1, 3 * P46, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rest note1 start: got %0d want 1", cur_note); end
        #1 obs_q.delete();
        repeat (3000) @(negedge clk50mhz);
        note_in = 6'd0;
        repeat (3) @(negedge clk50mhz);
        checks++; if (chg_pend !== 1'b1) begin failures++; $display("FAIL rest pend: got %b want 1", chg_pend); end
        exp_q.push_back('{6'd1, P1, H1});
        wait_obs(1, P1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rest timeout: got %0d periods want 1", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.size() > 0 ? obs_q.pop_front() : '0;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rest period: got note=%0d len=%0d high=%0d want note=%0d len=%0d high=%0d",
                         o.note, o.len, o.high, e.note, e.len, e.high);
            end
        end
        strobed = 1'b0;
        repeat (50) begin
            @(negedge clk50mhz);
            if (per_strobe !== 1'b0 || tone_out !== 1'b0) strobed = 1'b1;
        end
        checks++; if (strobed) begin failures++; $display("FAIL rest silent: got activity=1 want 0"); end
        checks++; if (cur_note !== 6'd0) begin failures++; $display("FAIL rest cur_note: got %0d want 0", cur_note); end
        note_in = 6'd34;
        wait_note(6'd34, 20, ok);
        repeat (100) @(negedge clk50mhz);
        en = 1'b0;
        @(posedge clk50mhz);
        #1;
        checks++; if (tone_out !== 1'b0) begin failures++; $display("FAIL mute tone_out: got %b want 0", tone_out); end
        checks++; if (cur_note !== 6'd0) begin failures++; $display("FAIL mute cur_note: got %0d want 0", cur_note); end
        note_in = 6'd0;
        @(negedge clk50mhz);
        #1 obs_q.delete();
        en = 1'b1;
    endtask

    task automatic test_return;
        note_in = 6'd34;
        wait_note(6'd34, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL return start: got %0d want 34", cur_note); end
        #1 obs_q.delete();
        repeat (200) @(negedge clk50mhz);
        note_in = 6'd40;
        repeat (3) @(negedge clk50mhz);
        checks++; if (chg_pend !== 1'b1) begin failures++; $display("FAIL return pend set: got %b want 1", chg_pend); end
        note_in = 6'd34;
        repeat (3) @(negedge clk50mhz);
        checks++; if (chg_pend !== 1'b0) begin failures++; $display("FAIL return pend clear: got %b want 0", chg_pend); end
        repeat (2) exp_q.push_back('{6'd34, P34, H34});
        wait_obs(2, 3 * P34, ok);
        checks++; if (!ok) begin failures++; $display("FAIL return timeout: got %0d periods want 2", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.size() > 0 ? obs_q.pop_front() : '0;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL return period: got note=%0d len=%0d high=%0d want note=%0d len=%0d high=%0d",
                         o.note, o.len, o.high, e.note, e.len, e.high);
            end
        end
    endtask

`ifdef NOTE_TONE_DUTY_EN
    task automatic test_duty;
        en = 1'b0; note_in = 6'd0;
        repeat (3) @(negedge clk50mhz);
        #1 obs_q.delete();
        en = 1'b1; duty_sel = 2'd2; note_in = 6'd63;
        wait_note(6'd63, 20, ok);
        #1 obs_q.delete();
        repeat (50) @(negedge clk50mhz);
        duty_sel = 2'd0;
        exp_q.push_back('{6'd63, P63, P63 >> 3});
        exp_q.push_back('{6'd63, P63, P63 >> 1});
        wait_obs(2, 3 * P63, ok);
        checks++; if (!ok) begin failures++; $display("FAIL duty timeout: got %0d periods want 2", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.size() > 0 ? obs_q.pop_front() : '0;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL duty period: got note=%0d len=%0d high=%0d want note=%0d len=%0d high=%0d",
                         o.note, o.len, o.high, e.note, e.len, e.high);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_async_reset();
        test_tone();
        test_note_change();
        test_rest();
        test_return();
`ifdef NOTE_TONE_DUTY_EN
        test_duty();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
